// File: rtl/real_top_mul_share_arb.sv
// Round-robin arbiter that shares one external combinational multiplier
// among NUM_REQ requesters. The product is held in a one-entry result
// register tagged with the requester index, with valid/ready backpressure.
module real_top_mul_share_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DIN0_WIDTH = 8,
  parameter int unsigned DIN1_WIDTH = 2,
  parameter int unsigned DOUT_WIDTH = 8
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]  req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]  req_din1,
  output logic [DIN0_WIDTH-1:0]          mul_din0,
  output logic [DIN1_WIDTH-1:0]          mul_din1,
  input  logic [DOUT_WIDTH-1:0]          mul_dout,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DOUT_WIDTH-1:0]          rsp_dout,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [15:0]                    issue_cnt
);

  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ID_WIDTH-1:0]     r_rr_ptr;
  logic [ID_WIDTH-1:0]     r_rsp_id;
  logic [DOUT_WIDTH-1:0]   r_rsp_dout;
  logic [CNT_WIDTH-1:0]    r_issue_cnt;

  logic                    w_any;
  logic [ID_WIDTH-1:0]     w_gnt;
  logic [ID_WIDTH-1:0]     w_idx;
  logic                    w_can_accept;
  logic                    w_accept;
  logic                    w_drain;

  assign rsp_valid    = (r_state == ST_FULL);
  assign rsp_dout     = r_rsp_dout;
  assign rsp_id       = r_rsp_id;
  assign issue_cnt    = r_issue_cnt;

  // The result slot frees up either when empty or when it drains this cycle.
  assign w_can_accept = (r_state == ST_EMPTY) | (rsp_ready & rsp_valid);
  assign w_accept     = w_any & w_can_accept;
  assign w_drain      = rsp_valid & rsp_ready;

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  // Steer the granted operands to the multiplier and raise its ready bit.
  always_comb begin
    mul_din0  = '0;
    mul_din1  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_any && (w_gnt == ID_WIDTH'(i))) begin
        mul_din0     = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
        mul_din1     = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
        req_ready[i] = w_can_accept;
      end
    end
  end

  // Result slot FSM, capture register, round-robin pointer and issue counter.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= ST_EMPTY;
      r_rr_ptr    <= '0;
      r_rsp_id    <= '0;
      r_rsp_dout  <= '0;
      r_issue_cnt <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (!w_accept && w_drain) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase

      if (w_accept) begin
        r_rsp_dout  <= mul_dout;
        r_rsp_id    <= w_gnt;
        r_rr_ptr    <= (w_gnt == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt + ID_WIDTH'(1);
        r_issue_cnt <= r_issue_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_real_top_mul_share_arb.sv
// Scoreboard bench for real_top_mul_share_arb: a driver issues stimulus and
// pushes expected results from a reference model; a monitor pops and compares.
module tb_real_top_mul_share_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned D0W = 8;
  localparam int unsigned D1W = 2;
  localparam int unsigned DOW = 8;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*D0W-1:0]     req_din0;
  logic [N*D1W-1:0]     req_din1;
  logic [D0W-1:0]       mul_din0;
  logic [D1W-1:0]       mul_din1;
  logic [DOW-1:0]       mul_dout;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DOW-1:0]       rsp_dout;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          issue_cnt;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DOW-1:0] dout;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   m_ptr  = 0;
  bit   m_full = 1'b0;
  int   m_cnt  = 0;

  always #5 ap_clk = ~ap_clk;

  // External combinational multiplier: signed x unsigned, low 8 bits kept.
  always_comb begin
    int p;
    p = int'($signed(mul_din0)) * int'(mul_din1);
    mul_dout = p[DOW-1:0];
  end

  real_top_mul_share_arb #(
    .NUM_REQ(N), .ID_WIDTH(IDW), .DIN0_WIDTH(D0W), .DIN1_WIDTH(D1W), .DOUT_WIDTH(DOW)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dout  (rsp_dout),
    .rsp_id    (rsp_id),
    .issue_cnt (issue_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result transfers at the next edge whenever valid & ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got unexpected result id=%0d dout=0x%0h", rsp_id, rsp_dout);
        end else begin
          e = sb.pop_front();
          chk("rsp_dout", longint'(rsp_dout), longint'(e.dout));
          chk("rsp_id", longint'(rsp_id), longint'(e.id));
        end
      end
    end
  end

  // One cycle of stimulus; called just after a rising edge, returns just after the next.
  task automatic drive(input logic [N-1:0] v, input logic [N*D0W-1:0] d0,
                       input logic [N*D1W-1:0] d1, input logic rdy);
    int              gnt;
    int              idx;
    bit              any;
    bit              acc;
    logic [N-1:0]    exp_rdy;
    logic [D0W-1:0]  e0;
    logic [D1W-1:0]  e1;
    int              prod;
    exp_t            e;
    req_valid = v;
    req_din0  = d0;
    req_din1  = d1;
    rsp_ready = rdy;
    #1;
    any = 1'b0;
    gnt = 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (!any && v[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
    acc     = any && (!m_full || rdy);
    exp_rdy = '0;
    if (acc) exp_rdy[gnt] = 1'b1;
    e0 = any ? d0[gnt*D0W +: D0W] : '0;
    e1 = any ? d1[gnt*D1W +: D1W] : '0;
    chk("rsp_valid", longint'(rsp_valid), longint'(m_full));
    chk("issue_cnt", longint'(issue_cnt), longint'(m_cnt));
    chk("req_ready", longint'(req_ready), longint'(exp_rdy));
    chk("mul_din0", longint'(mul_din0), longint'(e0));
    chk("mul_din1", longint'(mul_din1), longint'(e1));
    if (acc) begin
      prod   = int'($signed(e0)) * int'(e1);
      e.id   = IDW'(gnt);
      e.dout = prod[DOW-1:0];
      sb.push_back(e);
      m_ptr  = (gnt + 1) % N;
      m_cnt  = (m_cnt + 1) % 65536;
      m_full = 1'b1;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr  = 0;
    m_full = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic do_reset();
    ap_rst    = 1'b1;
    req_valid = '0;
    req_din0  = '0;
    req_din1  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [N*D0W-1:0] rand_d0();
    logic [N*D0W-1:0] r;
    for (int i = 0; i < N; i++) r[i*D0W +: D0W] = D0W'($urandom);
    return r;
  endfunction

  function automatic logic [N*D1W-1:0] rand_d1();
    logic [N*D1W-1:0] r;
    for (int i = 0; i < N; i++) r[i*D1W +: D1W] = D1W'($urandom);
    return r;
  endfunction

  initial begin
    logic [N*D0W-1:0] d0;
    logic [N*D1W-1:0] d1;
    logic [DOW-1:0]   held_dout;
    logic [IDW-1:0]   held_id;

    do_reset();
    chk("reset_valid", longint'(rsp_valid), 0);
    chk("reset_dout", longint'(rsp_dout), 0);
    chk("reset_id", longint'(rsp_id), 0);
    chk("reset_cnt", longint'(issue_cnt), 0);

    // -3 x 2 = -6
    d0 = '0; d1 = '0;
    d0[7:0] = 8'hFD; d1[1:0] = 2'd2;
    drive(4'b0001, d0, d1, 1'b1);
    chk("tp1_dout", longint'(rsp_dout), 8'hFA);
    chk("tp1_id", longint'(rsp_id), 0);
    chk("tp1_cnt", longint'(issue_cnt), 1);

    // Wrap cases, each on the currently granted requester (all lanes equal)
    d0 = {N{8'd100}}; d1 = {N{2'd3}};
    drive(4'b1111, d0, d1, 1'b1);
    chk("wrap_300", longint'(rsp_dout), 8'h2C);
    d0 = {N{8'h80}}; d1 = {N{2'd3}};
    drive(4'b1111, d0, d1, 1'b1);
    chk("wrap_m384", longint'(rsp_dout), 8'h80);
    d0 = {N{8'h7F}}; d1 = {N{2'd0}};
    drive(4'b1111, d0, d1, 1'b1);
    chk("mul_by_zero", longint'(rsp_dout), 8'h00);

    // All four requesting: strict rotation, one result per cycle
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, rand_d0(), rand_d1(), 1'b1);
      chk("rr_seq_id", longint'(rsp_id), c % N);
    end
    chk("rr_seq_cnt", longint'(issue_cnt), 8);

    // Backpressure: result held, no grants, then drain + accept together
    drive(4'b1111, rand_d0(), rand_d1(), 1'b0);
    held_dout = rsp_dout;
    held_id   = rsp_id;
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, rand_d0(), rand_d1(), 1'b0);
      chk("bp_hold_dout", longint'(rsp_dout), longint'(held_dout));
      chk("bp_hold_id", longint'(rsp_id), longint'(held_id));
    end
    drive(4'b1111, rand_d0(), rand_d1(), 1'b1);
    chk("bp_resume_id", longint'(rsp_id), (held_id + 1) % N);

    // Sparse: reach rr_ptr=3, then 0100 -> 2, 0001 -> 0, then idle
    do_reset();
    drive(4'b0100, rand_d0(), rand_d1(), 1'b1);
    chk("sparse_a", longint'(rsp_id), 2);
    drive(4'b0100, rand_d0(), rand_d1(), 1'b1);
    chk("sparse_b", longint'(rsp_id), 2);
    drive(4'b0001, rand_d0(), rand_d1(), 1'b1);
    chk("sparse_c", longint'(rsp_id), 0);
    drive(4'b0000, rand_d0(), rand_d1(), 1'b1);
    drive(4'b0000, rand_d0(), rand_d1(), 1'b1);
    chk("idle_valid", longint'(rsp_valid), 0);

    // Asynchronous reset while FULL, then first grant to requester 0
    drive(4'b0100, rand_d0(), rand_d1(), 1'b0);
    #1;
    ap_rst = 1'b1;
    #1;
    chk("arst_valid", longint'(rsp_valid), 0);
    chk("arst_dout", longint'(rsp_dout), 0);
    chk("arst_id", longint'(rsp_id), 0);
    chk("arst_cnt", longint'(issue_cnt), 0);
    model_reset();
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    drive(4'b1111, rand_d0(), rand_d1(), 1'b1);
    chk("arst_first_gnt", longint'(rsp_id), 0);

    // Randomised traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      drive(N'($urandom), rand_d0(), rand_d1(), 1'($urandom_range(0, 3) != 0));
    end

    // Issue counter wraps after 65536 accepts
    do_reset();
    for (int c = 0; c < 65536; c++) begin
      drive(N'($urandom_range(1, (1 << N) - 1)), rand_d0(), rand_d1(), 1'b1);
    end
    chk("cnt_wrap", longint'(issue_cnt), 0);

    // Drain and confirm every expected result was seen
    for (int c = 0; c < 4; c++) drive('0, '0, '0, 1'b1);
    chk("sb_empty", longint'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
